// File: rtl/jt51_wrq_pkg.sv
// Shared definitions for the jt51 host write queue: FSM encoding and FIFO entry layout.
package jt51_wrq_pkg;

   localparam int ENTRY_W = 16;

   // Entry layout: register address in [15:8], register value in [7:0]
   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wrq_entry_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ADDR  = 3'd1;
   localparam logic [2:0] ST_GAP   = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_GUARD = 3'd4;
   localparam logic [2:0] ST_POLL  = 3'd5;

endpackage

// File: rtl/jt51_wrq_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty come straight from registered pointers.
module jt51_wrq_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [WIDTH-1:0]    mem_d [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
   logic                do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                  (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign level = wr_ptr_q - rd_ptr_q;
   assign dout  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = din;
         wr_ptr_d = wr_ptr_q + (DEPTH_LOG2+1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (DEPTH_LOG2+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/jt51_wrqueue.sv
// Host write queue replaying {addr,data} pairs as YM2151 address/data bus writes.
// Optional occupancy and drop statistics: define JT51_WRQ_STATS_EN.
module jt51_wrqueue
   import jt51_wrq_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int BUSY_GUARD = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cen_p1,
   input  logic                host_wr,
   input  logic [7:0]          host_addr,
   input  logic [7:0]          host_data,
   output logic                host_ready,
   output logic                idle,
   output logic                cs_n,
   output logic                wr_n,
   output logic                a0,
   output logic [7:0]          din,
   input  logic [7:0]          dout,
   output logic [DEPTH_LOG2:0] level,
   output logic [7:0]          ovf_cnt
);

   localparam int GW = (BUSY_GUARD > 1) ? $clog2(BUSY_GUARD) : 1;

   logic [2:0]          state_q, state_d;
   logic [7:0]          data_q, data_d;
   logic [GW-1:0]       gcnt_q, gcnt_d;
   logic                cs_n_q, cs_n_d;
   logic                wr_n_q, wr_n_d;
   logic                a0_q, a0_d;
   logic [7:0]          din_q, din_d;

   logic                fifo_full, fifo_empty, fifo_pop, push;
   logic [ENTRY_W-1:0]  fifo_dout;
   logic [DEPTH_LOG2:0] fifo_level;
   wrq_entry_t          fifo_rd;
   logic                unused_dout;

   assign host_ready  = ~rst & ~fifo_full;
   assign push        = host_wr & host_ready;
   assign fifo_rd     = wrq_entry_t'(fifo_dout);
   assign idle        = fifo_empty & (state_q == ST_IDLE);
   assign unused_dout = ^dout[6:0];

   jt51_wrq_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (fifo_pop),
      .din   ({host_addr, host_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Bus outputs are registered alongside the state so a strobe spans exactly
   // the cycles up to and including the first cen_p1 tick of that state.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      gcnt_d   = gcnt_q;
      cs_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      a0_d     = a0_q;
      din_d    = din_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               data_d   = fifo_rd.data;
               din_d    = fifo_rd.addr;
               a0_d     = 1'b0;
               cs_n_d   = 1'b0;
               wr_n_d   = 1'b0;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (cen_p1) begin
               state_d = ST_GAP;
            end else begin
               cs_n_d = 1'b0;
               wr_n_d = 1'b0;
            end
         end
         ST_GAP: begin
            if (cen_p1) begin
               state_d = ST_DATA;
               a0_d    = 1'b1;
               din_d   = data_q;
               cs_n_d  = 1'b0;
               wr_n_d  = 1'b0;
            end
         end
         ST_DATA: begin
            if (cen_p1) begin
               gcnt_d  = '0;
               state_d = (BUSY_GUARD == 0) ? ST_POLL : ST_GUARD;
            end else begin
               cs_n_d = 1'b0;
               wr_n_d = 1'b0;
            end
         end
         ST_GUARD: begin
            // busy is not valid right after a data write, so skip a few ticks
            if (cen_p1) begin
               if (gcnt_q == GW'(BUSY_GUARD - 1)) state_d = ST_POLL;
               else gcnt_d = gcnt_q + GW'(1);
            end
         end
         ST_POLL: begin
            if (cen_p1 && !dout[7]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         gcnt_q  <= '0;
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         a0_q    <= 1'b0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         gcnt_q  <= gcnt_d;
         cs_n_q  <= cs_n_d;
         wr_n_q  <= wr_n_d;
         a0_q    <= a0_d;
         din_q   <= din_d;
      end
   end

   assign cs_n = cs_n_q;
   assign wr_n = wr_n_q;
   assign a0   = a0_q;
   assign din  = din_q;

`ifdef JT51_WRQ_STATS_EN
   logic [7:0] ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (host_wr && !host_ready && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) ovf_q <= '0;
      else     ovf_q <= ovf_d;
   end

   assign ovf_cnt = ovf_q;
   assign level   = fifo_level;
`else
   logic unused_level;
   assign unused_level = ^fifo_level;
   assign ovf_cnt      = '0;
   assign level        = '0;
`endif

endmodule
